// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and
// the load unit, with a registered write port and a per-register busy scoreboard.
module regfile_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [DATA_W-1:0]    req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req1_ready,
  input  logic                 wr_hold,
  input  logic                 rsv_valid,
  input  logic [ADDR_W-1:0]    rsv_addr,
  input  logic [ADDR_W-1:0]    rd1_addr,
  input  logic [ADDR_W-1:0]    rd2_addr,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 rd1_busy,
  output logic                 rd2_busy,
  output logic [2**ADDR_W-1:0] busy_mask
);

  localparam int NREG = 2**ADDR_W;

  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   busy_nxt;

  // last_grant resets to 1 so source 0 wins the first tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!wr_hold) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 || grant1;
  assign sel_addr   = grant1 ? req1_addr : req0_addr;
  assign sel_data   = grant1 ? req1_data : req0_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      last_grant <= 1'b1;
    end else begin
      wr_en <= accept && (sel_addr != '0);
      if (accept) begin
        wr_addr    <= sel_addr;
        wr_data    <= sel_data;
        last_grant <= grant1;
      end
    end
  end

  // Clear applies first so a same-edge reservation of the written register wins.
  always_comb begin
    busy_nxt = busy_mask;
    if (wr_en)
      busy_nxt[wr_addr] = 1'b0;
    if (rsv_valid)
      busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy_mask <= '0;
    else
      busy_mask <= busy_nxt;
  end

  assign rd1_busy = busy_mask[rd1_addr];
  assign rd2_busy = busy_mask[rd2_addr];

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: arbitration, latency, address-0 drop,
// scoreboard set/clear priority, stall, and asynchronous reset.
module tb_regfile_wr_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic              wr_hold, rsv_valid;
  logic [ADDR_W-1:0] rsv_addr, rd1_addr, rd2_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd1_busy, rd2_busy;
  logic [31:0]       busy_mask;

  int checks = 0;
  int errors = 0;

  regfile_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .wr_hold(wr_hold), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd1_busy(rd1_busy), .rd2_busy(rd2_busy), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    wr_hold = 1'b0; rsv_valid = 1'b0; rsv_addr = '0;
    rd1_addr = '0; rd2_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_busy", 64'(busy_mask), 64'd0);
    chk("rst_rd1_busy", 64'(rd1_busy), 64'd0);

    // Both sources valid: alternate 0,1,0,1 starting with source 0.
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h0000_0111;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h0000_0222;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_ready0_%0d", i), 64'(req0_ready), 64'((i % 2) == 0));
      chk($sformatf("rr_ready1_%0d", i), 64'(req1_ready), 64'((i % 2) == 1));
      tick();
      chk($sformatf("rr_wr_en_%0d", i), 64'(wr_en), 64'd1);
      chk($sformatf("rr_wr_addr_%0d", i), 64'(wr_addr), (i % 2) == 0 ? 64'd1 : 64'd2);
      chk($sformatf("rr_wr_data_%0d", i), 64'(wr_data), (i % 2) == 0 ? 64'h111 : 64'h222);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("rr_idle_wr_en", 64'(wr_en), 64'd0);

    // Single write, latency 1.
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h0000_1234;
    #1;
    chk("single_ready0", 64'(req0_ready), 64'd1);
    chk("single_ready1", 64'(req1_ready), 64'd0);
    tick();
    req0_valid = 1'b0;
    chk("single_wr_en", 64'(wr_en), 64'd1);
    chk("single_wr_addr", 64'(wr_addr), 64'd5);
    chk("single_wr_data", 64'(wr_data), 64'h1234);
    tick();
    chk("single_wr_en_off", 64'(wr_en), 64'd0);
    chk("single_wr_addr_hold", 64'(wr_addr), 64'd5);

    // Address 0: accepted but discarded; reservation of r0 ignored.
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000_FFFF;
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    #1;
    chk("a0_ready1", 64'(req1_ready), 64'd1);
    tick();
    req1_valid = 1'b0; rsv_valid = 1'b0;
    chk("a0_wr_en", 64'(wr_en), 64'd0);
    chk("a0_busy", 64'(busy_mask), 64'd0);

    // Scoreboard: reserve r7, write it, clear one cycle after wr_en.
    rsv_valid = 1'b1; rsv_addr = 5'd7; rd1_addr = 5'd7; rd2_addr = 5'd0;
    tick();
    rsv_valid = 1'b0;
    chk("sb_set", 64'(busy_mask), 64'h80);
    chk("sb_rd1_busy", 64'(rd1_busy), 64'd1);
    chk("sb_rd2_busy_r0", 64'(rd2_busy), 64'd0);
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_0077;
    #1;
    chk("sb_ready0", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    chk("sb_wr_en", 64'(wr_en), 64'd1);
    chk("sb_still_busy", 64'(busy_mask), 64'h80);
    tick();
    chk("sb_cleared", 64'(busy_mask), 64'h0);
    chk("sb_rd1_clear", 64'(rd1_busy), 64'd0);

    // Re-reserve r7 on the very edge its write clears it: set wins.
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    tick();
    rsv_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_0078;
    tick();
    req0_valid = 1'b0;
    chk("sb2_wr_en", 64'(wr_en), 64'd1);
    rsv_valid = 1'b1; rsv_addr = 5'd7; rd2_addr = 5'd7;
    tick();
    rsv_valid = 1'b0;
    chk("sb2_set_wins", 64'(busy_mask), 64'h80);
    chk("sb2_rd2_busy", 64'(rd2_busy), 64'd1);

    // Unreserved write in flight, then asynchronous reset mid-stream.
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000_0333;
    tick();
    req0_valid = 1'b0;
    chk("mid_wr_en", 64'(wr_en), 64'd1);
    chk("mid_busy_kept", 64'(busy_mask), 64'h80);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wr_en", 64'(wr_en), 64'd0);
    chk("arst_wr_addr", 64'(wr_addr), 64'd0);
    chk("arst_wr_data", 64'(wr_data), 64'd0);
    chk("arst_busy", 64'(busy_mask), 64'd0);
    chk("arst_rd1_busy", 64'(rd1_busy), 64'd0);
    tick();
    rst = 1'b0;

    // Stall with both valid, then release: source 0 first.
    wr_hold = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h0000_0A0A;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h0000_0B0B;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold_ready0_%0d", i), 64'(req0_ready), 64'd0);
      chk($sformatf("hold_ready1_%0d", i), 64'(req1_ready), 64'd0);
      tick();
      chk($sformatf("hold_wr_en_%0d", i), 64'(wr_en), 64'd0);
    end
    wr_hold = 1'b0;
    #1;
    chk("rel_ready0", 64'(req0_ready), 64'd1);
    chk("rel_ready1", 64'(req1_ready), 64'd0);
    tick();
    chk("rel_wr_addr", 64'(wr_addr), 64'd1);
    chk("rel_wr_data", 64'(wr_data), 64'h0A0A);
    #1;
    chk("rel_next_ready1", 64'(req1_ready), 64'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
